// File: rtl/halton_vertex_collector.sv
// halton_vertex_collector: pairs base-2/base-3 Halton samples into vertices behind per-stream FIFOs.
module halton_vertex_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    assign dout  = mem[rp];
    assign empty = cnt == '0;
    assign full  = cnt == (AW+1)'(DEPTH);
    always_ff @(posedge clk)
        if (push) mem[wp] <= din;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (clr) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= wp + AW'(push);
            rp  <= rp + AW'(pop);
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
endmodule

module halton_vertex_collector #(
    parameter int  MAP_WIDTH  = 1000,
    parameter int  FIFO_DEPTH = 8,
    localparam int VW         = $clog2(MAP_WIDTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic [15:0]   numNode_i,
    input  logic [VW-1:0] x_value_i,
    input  logic [15:0]   x_index_i,
    input  logic          x_valid_i,
    input  logic [VW-1:0] y_value_i,
    input  logic [15:0]   y_index_i,
    input  logic          y_valid_i,
    output logic [VW-1:0] vertex_x_o,
    output logic [VW-1:0] vertex_y_o,
    output logic [15:0]   vertex_index_o,
    output logic          vertex_valid_o,
    input  logic          vertex_ready_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          overflow_o,
    output logic          index_err_o
);
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
    state_t state, state_n;
    logic [15:0] num, cnt;
    logic [VW+15:0] x_q, y_q;
    logic x_empty, x_full, y_empty, y_full;
    logic acc, fin, active, pop, push_x, push_y, clr;
    assign acc    = vertex_valid_o & vertex_ready_i;
    assign fin    = state == COLLECT && acc && cnt + 16'd1 == num;
    // the final accept closes the run, so nothing is pushed or popped in that cycle
    assign active = state == COLLECT && !start_i && !fin;
    assign pop    = active && !x_empty && !y_empty && (!vertex_valid_o || acc);
    assign push_x = active && x_valid_i && (!x_full || pop);
    assign push_y = active && y_valid_i && (!y_full || pop);
    assign clr    = start_i | fin;
    assign busy_o = state == COLLECT;
    assign done_o = state == DONE;
    halton_vertex_fifo #(.W(VW + 16), .DEPTH(FIFO_DEPTH)) u_x_fifo (
        .clk(clk), .reset(reset), .clr(clr), .push(push_x), .pop(pop),
        .din({x_index_i, x_value_i}), .dout(x_q), .empty(x_empty), .full(x_full)
    );
    halton_vertex_fifo #(.W(VW + 16), .DEPTH(FIFO_DEPTH)) u_y_fifo (
        .clk(clk), .reset(reset), .clr(clr), .push(push_y), .pop(pop),
        .din({y_index_i, y_value_i}), .dout(y_q), .empty(y_empty), .full(y_full)
    );
    always_comb
        state_n = start_i ? (numNode_i == 16'd0 ? DONE : COLLECT) : fin ? DONE : state;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            num            <= '0;
            cnt            <= '0;
            vertex_x_o     <= '0;
            vertex_y_o     <= '0;
            vertex_index_o <= '0;
            vertex_valid_o <= 1'b0;
            overflow_o     <= 1'b0;
            index_err_o    <= 1'b0;
        end else if (start_i) begin
            num            <= numNode_i;
            cnt            <= '0;
            vertex_x_o     <= '0;
            vertex_y_o     <= '0;
            vertex_index_o <= '0;
            vertex_valid_o <= 1'b0;
            overflow_o     <= 1'b0;
            index_err_o    <= 1'b0;
        end else begin
            if (pop) begin
                vertex_x_o     <= x_q[VW-1:0];
                vertex_y_o     <= y_q[VW-1:0];
                vertex_index_o <= x_q[VW+15:VW];
                vertex_valid_o <= 1'b1;
            end else if (acc) vertex_valid_o <= 1'b0;
            if (pop && x_q[VW+15:VW] != y_q[VW+15:VW]) index_err_o <= 1'b1;
            if (active && !pop && ((x_valid_i && x_full) || (y_valid_i && y_full))) overflow_o <= 1'b1;
            if (acc) cnt <= cnt + 16'd1;
        end
endmodule

// File: tb/tb_halton_vertex_collector.sv
// tb_halton_vertex_collector: directed vectors for the Halton vertex collector.
module tb_halton_vertex_collector;
    localparam int VW = 10;
    logic clk = 0, reset = 1, start_i = 0;
    logic [15:0] numNode_i = 0;
    logic [VW-1:0] x_value_i = 0, y_value_i = 0;
    logic [15:0] x_index_i = 0, y_index_i = 0;
    logic x_valid_i = 0, y_valid_i = 0, vertex_ready_i = 0;
    logic [VW-1:0] vertex_x_o, vertex_y_o;
    logic [15:0] vertex_index_o;
    logic vertex_valid_o, busy_o, done_o, overflow_o, index_err_o;
    int n_vec = 0, n_err = 0;
    logic [35:0] q[$];
    int xs[4] = '{500, 250, 750, 125};
    int ys[4] = '{333, 666, 111, 444};

    halton_vertex_collector dut (
        .clk(clk), .reset(reset), .start_i(start_i), .numNode_i(numNode_i),
        .x_value_i(x_value_i), .x_index_i(x_index_i), .x_valid_i(x_valid_i),
        .y_value_i(y_value_i), .y_index_i(y_index_i), .y_valid_i(y_valid_i),
        .vertex_x_o(vertex_x_o), .vertex_y_o(vertex_y_o), .vertex_index_o(vertex_index_o),
        .vertex_valid_o(vertex_valid_o), .vertex_ready_i(vertex_ready_i),
        .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o), .index_err_o(index_err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!reset && vertex_valid_o && vertex_ready_i)
            q.push_back({vertex_x_o, vertex_y_o, vertex_index_o});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [15:0] n);
        start_i = 1;
        numNode_i = n;
        tick();
        start_i = 0;
        q.delete();
    endtask

    task automatic drive(input logic xv, input logic yv, input int xi, input int yi, input int xd, input int yd);
        x_valid_i = xv;
        y_valid_i = yv;
        x_index_i = 16'(xi);
        y_index_i = 16'(yi);
        x_value_i = VW'(xd);
        y_value_i = VW'(yd);
        tick();
        x_valid_i = 0;
        y_valid_i = 0;
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (!done_o && k < bound) begin
            tick();
            k++;
        end
        chk("done_reached", done_o, 1);
    endtask

    task automatic chk_vtx(input string tag, input int i, input int x, input int y, input int idx);
        if (i >= q.size()) chk({tag, "_missing"}, q.size(), i + 1);
        else begin
            chk({tag, "_x"}, q[i][35:26], x);
            chk({tag, "_y"}, q[i][25:16], y);
            chk({tag, "_idx"}, q[i][15:0], idx);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_valid", vertex_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_flags", {overflow_o, index_err_o}, 0);
        reset = 0;
        tick();

        // simultaneous streams
        vertex_ready_i = 1;
        start_run(4);
        chk("s1_busy", busy_o, 1);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, i, i, xs[i], ys[i]);
            if (i == 0) chk("s1_lat0", vertex_valid_o, 0);
            if (i == 1) begin
                chk("s1_lat1", vertex_valid_o, 1);
                chk("s1_first_x", vertex_x_o, 500);
            end
        end
        tick();
        chk("s1_done_early", done_o, 0);
        tick();
        chk("s1_done", done_o, 1);
        chk("s1_busy_end", busy_o, 0);
        chk("s1_valid_end", vertex_valid_o, 0);
        chk("s1_count", q.size(), 4);
        for (int i = 0; i < 4; i++) chk_vtx("s1_v", i, xs[i], ys[i], i);
        chk("s1_flags", {overflow_o, index_err_o}, 0);

        // skewed arrival: y trails x by 5 cycles
        start_run(4);
        for (int i = 0; i < 4; i++) drive(1, 0, i, 0, xs[i], 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, i, 0, ys[i]);
            if (i == 0) chk("s2_lat0", vertex_valid_o, 0);
            if (i == 1) begin
                chk("s2_lat1", vertex_valid_o, 1);
                chk("s2_first_y", vertex_y_o, 333);
            end
        end
        wait_done(20);
        chk("s2_count", q.size(), 4);
        for (int i = 0; i < 4; i++) chk_vtx("s2_v", i, xs[i], ys[i], i);

        // backpressure: 9 pairs, vertex 0 held, both FIFOs end full
        vertex_ready_i = 0;
        start_run(9);
        for (int i = 0; i < 9; i++) begin
            drive(1, 1, i + 16, i + 16, i * 100 + 1, i * 50 + 7);
            if (i >= 1) begin
                chk("s3_hold_valid", vertex_valid_o, 1);
                chk("s3_hold_x", vertex_x_o, 1);
                chk("s3_hold_y", vertex_y_o, 7);
                chk("s3_hold_idx", vertex_index_o, 16);
            end
        end
        tick();
        tick();
        chk("s3_hold_end", {vertex_valid_o, vertex_x_o}, {1'b1, 10'd1});
        chk("s3_no_ovf", overflow_o, 0);
        vertex_ready_i = 1;
        wait_done(30);
        chk("s3_count", q.size(), 9);
        for (int i = 0; i < 9; i++) chk_vtx("s3_v", i, i * 100 + 1, i * 50 + 7, i + 16);
        chk("s3_ovf_end", overflow_o, 0);

        // overflow: 9 x pushes with no y
        start_run(9);
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, i, 0, i * 100 + 1, 0);
            if (i == 7) chk("s4_ovf_8th", overflow_o, 0);
        end
        chk("s4_ovf_9th", overflow_o, 1);
        for (int i = 0; i < 8; i++) drive(0, 1, 0, i, 0, i * 50 + 7);
        for (int i = 0; i < 4; i++) tick();
        chk("s4_count", q.size(), 8);
        chk_vtx("s4_v7", 7, 701, 357, 7);
        chk("s4_not_done", {busy_o, done_o}, 2'b10);
        chk("s4_ierr", index_err_o, 0);

        // index mismatch
        start_run(1);
        chk("s5_ovf_cleared", overflow_o, 0);
        drive(1, 1, 3, 4, 10, 20);
        wait_done(10);
        chk("s5_count", q.size(), 1);
        chk_vtx("s5_v", 0, 10, 20, 3);
        chk("s5_ierr", index_err_o, 1);

        // numNode = 0
        start_run(0);
        chk("s6_done", done_o, 1);
        chk("s6_busy", busy_o, 0);
        chk("s6_ierr_cleared", index_err_o, 0);
        drive(1, 1, 0, 0, 5, 6);
        tick();
        chk("s6_no_vtx", vertex_valid_o, 0);
        chk("s6_count", q.size(), 0);

        // asynchronous reset after 2 vertices
        start_run(4);
        for (int i = 0; i < 4; i++) drive(1, 1, i, i, xs[i], ys[i]);
        chk("s7_two", q.size(), 2);
        #2 reset = 1;
        #1;
        chk("s7_rst_valid", vertex_valid_o, 0);
        chk("s7_rst_state", {busy_o, done_o}, 0);
        chk("s7_rst_vtx", {vertex_x_o, vertex_y_o, vertex_index_o}, 0);
        #10 reset = 0;
        tick();
        drive(1, 1, 9, 9, 9, 9);
        tick();
        chk("s7_idle_valid", vertex_valid_o, 0);
        chk("s7_no_more", q.size(), 2);
        start_run(1);
        drive(1, 1, 5, 5, 42, 43);
        wait_done(10);
        chk("s7_count", q.size(), 1);
        chk_vtx("s7_v", 0, 42, 43, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/halton_vertex_collector.md
# halton_vertex_collector

Consumer end of the Halton value streams. Takes the base-2 (x) and base-3 (y) `halton_sequence_value` outputs, which carry value/index/valid with no backpressure, and buffers each stream in its own FIFO. It pairs entries by arrival order into (x, y, index) vertices and hands them to the graph-builder over a valid/ready handshake. It also counts emitted vertices against the requested node count and flags overflow and index-mismatch errors.

## Interface
- MAP_WIDTH, 1000: map side length; coordinate width VW = $clog2(MAP_WIDTH+1) (10 at default).
- FIFO_DEPTH, 8: entries per input FIFO; power of two, ≥2.

- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start_i  in  1  one-cycle pulse; begins a collection run.
- numNode_i  in  16  vertices to emit; sampled on start_i.
- x_value_i  in  VW  base-2 value.
- x_index_i  in  16  base-2 index.
- x_valid_i  in  1  x sample present this cycle.
- y_value_i  in  VW  base-3 value.
- y_index_i  in  16  base-3 index.
- y_valid_i  in  1  y sample present this cycle.
- vertex_x_o  out  VW  vertex x coordinate.
- vertex_y_o  out  VW  vertex y coordinate.
- vertex_index_o  out  16  vertex index, taken from the x entry.
- vertex_valid_o  out  1  vertex output is valid.
- vertex_ready_i  in  1  downstream accepts the vertex.
- busy_o  out  1  high in COLLECT.
- done_o  out  1  high in DONE.
- overflow_o  out  1  sticky; an x or y sample was dropped because its FIFO was full.
- index_err_o  out  1  sticky; a popped pair had x_index ≠ y_index.

## Operation
- States:
  - IDLE: after reset.
  - COLLECT: entered on start_i.
  - DONE: entered when the emitted count reaches the latched numNode.
- start_i in any state:
  - latches numNode_i, clears the emit count, both FIFOs, the output register, overflow_o and index_err_o;
  - goes to COLLECT, or directly to DONE if numNode_i = 0.
- Push rules:
  - pushes happen only in COLLECT and not on the start_i cycle;
  - in IDLE and DONE, inputs are ignored.
- A push into a full FIFO drops the sample and sets overflow_o. The exception is when the same FIFO pops in that cycle; then the push succeeds.
- Pop condition: both FIFOs non-empty AND the output register is empty or being accepted (vertex_valid_o & vertex_ready_i). Both FIFOs pop together.
- On pop:
  - the output register loads {x value, y value, x index} and vertex_valid_o = 1;
  - if the indices differ, index_err_o is set and the vertex is still emitted.
- Output is held stable while vertex_valid_o & !vertex_ready_i.
- Each accepted transfer (valid & ready) increments the emit count.
- When an accepted transfer makes the count equal numNode, the state goes to DONE. Samples still in the FIFOs are discarded by clearing both FIFOs.
- done_o holds until the next start_i or reset.

## Timing
- Reset values:
  - all outputs 0;
  - state IDLE;
  - FIFOs empty, count 0, latched numNode 0.
- Asynchronous reset mid-run aborts immediately. No vertex is emitted afterwards until a new start_i.
- A push on cycle t makes the FIFO non-empty at t+1.
- Latency: vertex_valid_o rises at t+2, where t is the cycle in which the later of the two matching samples was pushed. This assumes the output register is free.
- Throughput: one vertex per cycle when ready is held high.
- done_o and busy_o change on the clock edge after the final accepted transfer.
- The count register is 16 bits. numNode_i = 65535 is legal, and the count never wraps within a run.

## Test plan
- Simultaneous streams:
  - stimulus: numNode=4; x values 500,250,750,125 and y values 333,666,111,444, indices 0..3, pushed on the same cycles; ready=1;
  - response: 4 vertices (500,333,0)…(125,444,3); done_o one cycle after the 4th; no error flags.
- Skewed arrival:
  - stimulus: all x pushed 5 cycles before the matching y;
  - response: vertices identical to the previous scenario; the first vertex_valid_o appears 2 cycles after the first y push.
- Backpressure:
  - stimulus: hold ready=0 for 10 cycles with vertex 0 pending;
  - response: outputs stable; the FIFOs absorb up to 8 samples with no overflow; after ready rises, all vertices drain in order.
- Overflow:
  - stimulus: 9 x pushes with no y, FIFO_DEPTH=8;
  - response: overflow_o=1 on the cycle after the 9th push; the 9th sample is lost.
- Index mismatch:
  - stimulus: x index 3 paired with y index 4;
  - response: index_err_o=1; the vertex is still emitted with index 3.
- Control edge cases:
  - stimulus 1: numNode=0 start;
  - response 1: done_o at the next edge, no vertices.
  - stimulus 2: reset asserted mid-run after 2 vertices;
  - response 2: all outputs 0 immediately; a new start with numNode=1 produces one vertex.
